// File: rtl/rnd_harvester_if.sv
// Output stream of rnd_harvester: FIFO head word, valid/ready handshake and occupancy.
interface rnd_harvester_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) ();
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] level;

  modport master (output out_data, output out_valid, output level, input out_ready);
  modport slave  (input out_data, input out_valid, input level, output out_ready);
endinterface

// File: rtl/rnd_harvester.sv
// Entropy harvester: synchronise one source, health-test, pack MSB-first, buffer in a FIFO.
// Optional von Neumann debiasing is compiled in with the RND_VN_DEBIAS_EN macro.
module rnd_harvester #(
  parameter int CHANNELS  = 8,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 32,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] entropy_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                freeze,
  input  logic                clr,
  rnd_harvester_if.master     out,
  output logic                overflow,
  output logic                stuck
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             sync1_q, sync2_q, prev_q;
  logic [SEL_W-1:0] sel_q;
  logic [1:0]       flush_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic [WIDTH-2:0] shreg_q;
  logic [REP_W-1:0] rep_q;
  logic             overflow_q, stuck_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q;

  logic             raw_bit, sel_change, flushing, cand_take, trip;
  logic             accept, acc_bit, push, pop, full, wr_en, drop;
  logic [REP_W-1:0] rep_cand;
  logic [WIDTH-1:0] word_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign raw_bit    = (int'(sel) < CHANNELS) ? entropy_in[sel] : 1'b0;
  assign sel_change = (sel != sel_q);
  assign flushing   = sel_change || (flush_q != 2'd0);
  assign cand_take  = !flushing && !freeze;
  // rep_q == 0 means no previous candidate since the last flush.
  assign rep_cand   = ((rep_q != '0) && (sync2_q == prev_q)) ? rep_q + REP_W'(1) : REP_W'(1);
  assign trip       = cand_take && (rep_cand == REP_W'(REP_LIMIT));

`ifdef RND_VN_DEBIAS_EN
  logic pair_have_q, pair_first_q;

  assign accept  = cand_take && !trip && pair_have_q && (pair_first_q != sync2_q);
  assign acc_bit = pair_first_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_have_q  <= 1'b0;
      pair_first_q <= 1'b0;
    end else if (flushing || trip) begin
      pair_have_q  <= 1'b0;
    end else if (cand_take) begin
      pair_have_q  <= !pair_have_q;
      if (!pair_have_q) pair_first_q <= sync2_q;
    end
  end
`else
  assign accept  = cand_take && !trip;
  assign acc_bit = sync2_q;
`endif

  assign word_next = {shreg_q, acc_bit};
  assign push      = accept && (bitcnt_q == CNT_W'(WIDTH - 1));
  assign pop       = (count_q != '0) && out.out_ready;
  assign full      = (count_q == LVL_W'(DEPTH));
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Left unreset so the select seen during reset does not trigger a second flush on release.
  always_ff @(posedge clk) begin
    sel_q <= sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      flush_q    <= 2'd2;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      rep_q      <= '0;
      overflow_q <= 1'b0;
      stuck_q    <= 1'b0;
    end else begin
      sync1_q <= raw_bit;
      sync2_q <= sync1_q;
      if (sel_change)            flush_q <= 2'd2;
      else if (flush_q != 2'd0)  flush_q <= flush_q - 2'd1;

      if (flushing) begin
        bitcnt_q <= '0;
        rep_q    <= '0;
      end else if (cand_take) begin
        prev_q <= sync2_q;
        if (trip) begin
          rep_q    <= REP_W'(1);
          bitcnt_q <= '0;
        end else begin
          rep_q <= rep_cand;
          if (accept) begin
            shreg_q  <= word_next[WIDTH-2:0];
            bitcnt_q <= push ? '0 : bitcnt_q + CNT_W'(1);
          end
        end
      end

      // A set event on the same cycle as clr takes priority.
      if (drop)     overflow_q <= 1'b1;
      else if (clr) overflow_q <= 1'b0;
      if (trip)     stuck_q    <= 1'b1;
      else if (clr) stuck_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= word_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (wr_en && !pop)      count_q <= count_q + LVL_W'(1);
      else if (!wr_en && pop) count_q <= count_q - LVL_W'(1);
    end
  end

  assign out.out_data  = (count_q != '0) ? mem[rd_ptr_q] : '0;
  assign out.out_valid = (count_q != '0);
  assign out.level     = count_q;
  assign overflow      = overflow_q;
  assign stuck         = stuck_q;
endmodule

// File: tb/tb_rnd_harvester.sv
// Directed bench for rnd_harvester: a queue-based reference model checked every cycle,
// plus literal expectations at hand-computed edges.
module tb_rnd_harvester;
  localparam int CH = 4, W = 8, D = 4, REP = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] entropy_in = '0;
  logic [1:0]    sel = 2'd1;
  logic          freeze = 1'b0, clr = 1'b0;
  logic          overflow, stuck;

  rnd_harvester_if #(.WIDTH(W), .DEPTH(D)) bus ();

  rnd_harvester #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D), .REP_LIMIT(REP)) dut (
    .clk(clk), .rst(rst), .entropy_in(entropy_in), .sel(sel), .freeze(freeze),
    .clr(clr), .out(bus), .overflow(overflow), .stuck(stuck)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit smp_q[$];          // samples in flight through the two-stage synchroniser
  bit bits_q[$];         // bits collected toward the current word
  int fifo_q[$];
  int m_sel, m_discard, m_run;
  bit m_last, m_ovf, m_stuck, pair_have, pair_first;

  always @(posedge clk) begin : model
    bit cand, newsmp, have_word, set_ovf, set_stuck, acc, b;
    int word;
    newsmp = entropy_in[sel];
    have_word = 0; set_ovf = 0; set_stuck = 0; word = 0;
    if (rst) begin
      smp_q = '{0, 0};
      bits_q.delete(); fifo_q.delete();
      m_discard = 2; m_run = 0; m_last = 0; m_ovf = 0; m_stuck = 0; pair_have = 0;
    end else begin
      cand = smp_q[0];
      if (int'(sel) != m_sel || m_discard > 0) begin
        m_discard = (int'(sel) != m_sel) ? 2 : m_discard - 1;
        bits_q.delete(); m_run = 0; pair_have = 0;
      end else if (!freeze) begin
        m_run = (m_run > 0 && cand == m_last) ? m_run + 1 : 1;
        m_last = cand;
        if (m_run == REP) begin
          set_stuck = 1; bits_q.delete(); pair_have = 0; m_run = 1;
        end else begin
          acc = 0; b = 0;
`ifdef RND_VN_DEBIAS_EN
          if (!pair_have) begin
            pair_first = cand; pair_have = 1;
          end else begin
            pair_have = 0;
            if (pair_first != cand) begin acc = 1; b = pair_first; end
          end
`else
          acc = 1; b = cand;
`endif
          if (acc) begin
            bits_q.push_back(b);
            if (bits_q.size() == W) begin
              foreach (bits_q[i]) word = word * 2 + int'(bits_q[i]);
              bits_q.delete(); have_word = 1;
            end
          end
        end
      end
      void'(smp_q.pop_front());
      smp_q.push_back(newsmp);
      if (fifo_q.size() > 0 && bus.out_ready) void'(fifo_q.pop_front());
      if (have_word) begin
        if (fifo_q.size() < D) fifo_q.push_back(word);
        else set_ovf = 1;
      end
      m_ovf   = set_ovf   ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_stuck = set_stuck ? 1'b1 : (clr ? 1'b0 : m_stuck);
    end
    m_sel = int'(sel);
  end

  always @(negedge clk) begin : compare
    if (!rst) begin
      check("cyc_valid", 32'(bus.out_valid), 32'(fifo_q.size() != 0));
      check("cyc_level", 32'(bus.level), 32'(fifo_q.size()));
      check("cyc_data", 32'(bus.out_data), (fifo_q.size() != 0) ? 32'(fifo_q[0]) : 32'd0);
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      check("cyc_stuck", 32'(stuck), 32'(m_stuck));
    end
  end

  // ---------------- stimulus ----------------
  int ecnt = 0;              // number of the upcoming clock edge since reset release
  int ch0_base = -1000;
  logic [31:0] seq0 = 32'hC53A_96F0;
  logic [7:0]  pat3 = 8'b1001_0011;

  task automatic tick();
    int idx;
    idx = ecnt - ch0_base;
    entropy_in[0] = (idx >= 0 && idx < 32) ? seq0[31-idx] : 1'b0;
    entropy_in[1] = ecnt[0];
    entropy_in[2] = 1'b0;
`ifdef RND_VN_DEBIAS_EN
    entropy_in[3] = pat3[7 - ((ecnt - 1) % 8)];
`else
    entropy_in[3] = ecnt[1];
`endif
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (ecnt <= n) tick();
  endtask

  int k, k2, k3, k4;

  initial begin
    bus.out_ready = 1'b0;
`ifdef RND_VN_DEBIAS_EN
    sel = 2'd3;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ecnt = 1;
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_level", 32'(bus.level), 32'd0);
    check("reset_data", 32'(bus.out_data), 32'd0);
    check("reset_flags", 32'({overflow, stuck}), 32'd0);
`ifdef RND_VN_DEBIAS_EN
    run_to(29);
    check("vn_not_yet", 32'(bus.out_valid), 32'd0);
    run_to(30);
    check("vn_valid", 32'(bus.out_valid), 32'd1);
    run_to(34);
    check("vn_data", 32'(bus.out_data), 32'hAA);
    check("vn_level", 32'(bus.level), 32'd1);
`else
    // First word: alternating stream on channel 1.
    run_to(9);
    check("first_not_yet", 32'(bus.out_valid), 32'd0);
    run_to(10);
    check("first_valid", 32'(bus.out_valid), 32'd1);
    check("first_data", 32'(bus.out_data), 32'hAA);
    check("first_level", 32'(bus.level), 32'd1);

    // Overflow: fill four entries, drop the fifth.
    run_to(34);
    check("fill_level", 32'(bus.level), 32'd4);
    check("fill_no_ovf", 32'(overflow), 32'd0);
    run_to(42);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(bus.level), 32'd4);
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    check("pop_data", 32'(bus.out_data), 32'hAA);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    check("pop_level", 32'(bus.level), 32'd3);
    bus.out_ready = 1'b1;
    run_to(60);

    // Stuck source on channel 2.
    sel = 2'd2; k = ecnt;
    run_to(k + 33);
    check("stuck_before", 32'(stuck), 32'd0);
    run_to(k + 34);
    check("stuck_set", 32'(stuck), 32'd1);
    check("stuck_no_push", 32'(bus.out_valid), 32'd0);
    run_to(k + 39);
    sel = 2'd3; k2 = ecnt;
    run_to(k2 + 9);
    check("resume_not_yet", 32'(bus.out_valid), 32'd0);
    run_to(k2 + 10);
    check("resume_valid", 32'(bus.out_valid), 32'd1);
    run_to(k2 + 11);
    clr = 1'b1; tick(); clr = 1'b0;
    check("stuck_clr", 32'(stuck), 32'd0);
    run_to(k2 + 15);

    // Channel switch after five accepted bits.
    sel = 2'd1; k3 = ecnt;
    tick();
    bus.out_ready = 1'b0;
    run_to(k3 + 7);
    sel = 2'd0; k4 = ecnt; ch0_base = k4 + 1;
    run_to(k4 + 9);
    check("switch_not_yet", 32'(bus.out_valid), 32'd0);
    run_to(k4 + 10);
    check("switch_valid", 32'(bus.out_valid), 32'd1);
    check("switch_data", 32'(bus.out_data), 32'hC5);

    // Freeze for 20 cycles after three bits of the next word.
    run_to(k4 + 13);
    freeze = 1'b1;
    run_to(k4 + 33);
    check("freeze_level", 32'(bus.level), 32'd1);
    freeze = 1'b0;
    run_to(k4 + 37);
    check("thaw_not_yet", 32'(bus.level), 32'd1);
    run_to(k4 + 38);
    check("thaw_level", 32'(bus.level), 32'd2);
    check("thaw_head", 32'(bus.out_data), 32'hC5);
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    check("thaw_word", 32'(bus.out_data), 32'h20);
    check("thaw_level_pop", 32'(bus.level), 32'd1);
`endif
    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
